// File: rtl/cp0_exception_unit_pkg.sv
// Shared constants and types for the CP0 exception unit.
// CP0 register numbers, ExcCodes, Status/Cause bit positions and reset defaults.
package cp0_exception_unit_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0A,
        EXC_OV   = 5'h0C
    } exc_code_e;

    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int ST_IM_HI = 15;
    localparam int ST_BEV   = 22;

    localparam logic [31:0] STATUS_WMASK    = 32'h0000_FF03;
    localparam logic [31:0] STATUS_BEV_MASK = 32'h0040_0000;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RST_DEF = 32'h0040_0000;

    // Cause is kept as its live fields; IP[7] is finalised at the top level.
    typedef struct packed {
        logic       bd;
        logic       ti;
        logic [5:0] ip_hw;
        logic [1:0] ip_sw;
        logic [4:0] exccode;
    } cause_t;

    function automatic logic [31:0] status_merge(input logic [31:0] wdata);
        return (wdata & STATUS_WMASK) | STATUS_BEV_MASK;
    endfunction

endpackage

// File: rtl/cp0_exception_unit_if.sv
// M-stage <-> CP0 signal bundle; the pipeline is master, the CP0 unit is slave.
interface cp0_exception_unit_if;
    import cp0_exception_unit_pkg::*;

    logic [5:0]  ext_int;
    logic [31:0] pcM;
    logic        in_delayslotM;
    logic        validM;
    logic        adel_pcM;
    logic        riM;
    logic        syscallM;
    logic        breakM;
    logic        eretM;
    logic        overflowM;
    logic        adelM;
    logic        adesM;
    logic [31:0] bad_addrM;
    logic        cp0_weM;
    logic [4:0]  cp0_waddrM;
    logic [31:0] cp0_wdataM;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        flush_exceptM;
    logic [31:0] except_pc;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;

    modport master (
        output ext_int, pcM, in_delayslotM, validM, adel_pcM, riM, syscallM,
               breakM, eretM, overflowM, adelM, adesM, bad_addrM,
               cp0_weM, cp0_waddrM, cp0_wdataM, cp0_raddr,
        input  cp0_rdata, flush_exceptM, except_pc, status_o, cause_o, epc_o
    );

    modport slave (
        input  ext_int, pcM, in_delayslotM, validM, adel_pcM, riM, syscallM,
               breakM, eretM, overflowM, adelM, adesM, bad_addrM,
               cp0_weM, cp0_waddrM, cp0_wdataM, cp0_raddr,
        output cp0_rdata, flush_exceptM, except_pc, status_o, cause_o, epc_o
    );

endinterface

// File: rtl/cp0_exception_unit_exc_priority.sv
// Combinational exception selector: picks the highest-priority pending event.
// ERET is reported separately and only when no real exception is selected.
module cp0_exc_priority
    import cp0_exception_unit_pkg::*;
(
    input  logic       int_pend_i,
    input  logic       adel_pc_i,
    input  logic       ri_i,
    input  logic       ov_i,
    input  logic       sys_i,
    input  logic       brk_i,
    input  logic       adel_i,
    input  logic       ades_i,
    input  logic       eret_i,
    output logic       exc_valid_o,
    output logic [4:0] exc_code_o,
    output logic       is_eret_o
);

    // Fixed priority chain, interrupt first, ERET last.
    always_comb begin
        exc_valid_o = 1'b1;
        exc_code_o  = EXC_INT;
        is_eret_o   = 1'b0;
        if (int_pend_i) begin
            exc_code_o = EXC_INT;
        end else if (adel_pc_i) begin
            exc_code_o = EXC_ADEL;
        end else if (ri_i) begin
            exc_code_o = EXC_RI;
        end else if (ov_i) begin
            exc_code_o = EXC_OV;
        end else if (sys_i) begin
            exc_code_o = EXC_SYS;
        end else if (brk_i) begin
            exc_code_o = EXC_BP;
        end else if (adel_i) begin
            exc_code_o = EXC_ADEL;
        end else if (ades_i) begin
            exc_code_o = EXC_ADES;
        end else if (eret_i) begin
            exc_valid_o = 1'b0;
            is_eret_o   = 1'b1;
        end else begin
            exc_valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/cp0_exception_unit.sv
// M-stage CP0: architectural registers, timer, interrupt/exception flush and redirect.
// Define CP0_TIMER_INT_EN to route Cause.TI into interrupt line IP[7].
module cp0_exception_unit
    import cp0_exception_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
    input logic                 clk,
    input logic                 resetn,
    cp0_exception_unit_if.slave bus
);

    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    cause_t      cause_q, cause_d;
    logic        tick_q, tick_d;

    logic [7:0]  ip_s;
    logic [31:0] cause_s;
    logic        int_pend_s;
    logic        exc_valid_s;
    logic        is_eret_s;
    logic [4:0]  exc_code_s;
    logic        mtc0_s;
    logic        flush_s;

`ifdef CP0_TIMER_INT_EN
    assign ip_s = {cause_q.ip_hw[5] | cause_q.ti, cause_q.ip_hw[4:0], cause_q.ip_sw};
`else
    assign ip_s = {cause_q.ip_hw, cause_q.ip_sw};
`endif

    assign cause_s    = {cause_q.bd, cause_q.ti, 14'h0000, ip_s, 1'b0, cause_q.exccode, 2'b00};
    assign int_pend_s = status_q[ST_IE] & ~status_q[ST_EXL]
                        & (|(ip_s & status_q[ST_IM_HI:ST_IM_LO]));
    assign mtc0_s     = bus.validM & bus.cp0_weM;

    cp0_exc_priority u_prio (
        .int_pend_i  (int_pend_s    & bus.validM),
        .adel_pc_i   (bus.adel_pcM  & bus.validM),
        .ri_i        (bus.riM       & bus.validM),
        .ov_i        (bus.overflowM & bus.validM),
        .sys_i       (bus.syscallM  & bus.validM),
        .brk_i       (bus.breakM    & bus.validM),
        .adel_i      (bus.adelM     & bus.validM),
        .ades_i      (bus.adesM     & bus.validM),
        .eret_i      (bus.eretM     & bus.validM),
        .exc_valid_o (exc_valid_s),
        .exc_code_o  (exc_code_s),
        .is_eret_o   (is_eret_s)
    );

    assign flush_s = exc_valid_s | is_eret_s;

    // Zero-latency flush/redirect, mfc0 read mux and register mirrors.
    always_comb begin
        bus.flush_exceptM = flush_s;
        bus.except_pc     = 32'h0000_0000;
        if (flush_s) begin
            bus.except_pc = is_eret_s ? epc_q : EXC_VECTOR;
        end else begin
            bus.except_pc = 32'h0000_0000;
        end
        case (bus.cp0_raddr)
            CP0_BADVADDR: bus.cp0_rdata = badvaddr_q;
            CP0_COUNT:    bus.cp0_rdata = count_q;
            CP0_COMPARE:  bus.cp0_rdata = compare_q;
            CP0_STATUS:   bus.cp0_rdata = status_q;
            CP0_CAUSE:    bus.cp0_rdata = cause_s;
            CP0_EPC:      bus.cp0_rdata = epc_q;
            default:      bus.cp0_rdata = 32'h0000_0000;
        endcase
        bus.status_o = status_q;
        bus.cause_o  = cause_s;
        bus.epc_o    = epc_q;
    end

    // Next state: timer, then mtc0, then exception/ERET overrides on top.
    always_comb begin
        badvaddr_d    = badvaddr_q;
        compare_d     = compare_q;
        status_d      = status_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        tick_d        = ~tick_q;
        count_d       = count_q + {31'd0, tick_q};
        cause_d.ti    = cause_q.ti | (count_q == compare_q);
        cause_d.ip_hw = bus.ext_int;

        if (mtc0_s) begin
            case (bus.cp0_waddrM)
                CP0_COUNT:   count_d = bus.cp0_wdataM;
                CP0_COMPARE: begin
                    compare_d  = bus.cp0_wdataM;
                    cause_d.ti = 1'b0;
                end
                CP0_STATUS:  status_d      = status_merge(bus.cp0_wdataM);
                CP0_CAUSE:   cause_d.ip_sw = bus.cp0_wdataM[9:8];
                CP0_EPC:     epc_d         = bus.cp0_wdataM;
                default:     ;
            endcase
        end else begin
            count_d = count_d;
        end

        if (exc_valid_s) begin
            cause_d.exccode = exc_code_s;
            if (!status_q[ST_EXL]) begin
                epc_d      = bus.in_delayslotM ? (bus.pcM - 32'd4) : bus.pcM;
                cause_d.bd = bus.in_delayslotM;
            end else begin
                cause_d.bd = cause_q.bd;
            end
            status_d[ST_EXL] = 1'b1;
            // adel_pcM outranks adelM, so an ADEL code with it set is the fetch fault.
            if (exc_code_s == EXC_ADEL) begin
                badvaddr_d = bus.adel_pcM ? bus.pcM : bus.bad_addrM;
            end else if (exc_code_s == EXC_ADES) begin
                badvaddr_d = bus.bad_addrM;
            end else begin
                badvaddr_d = badvaddr_q;
            end
        end else if (is_eret_s) begin
            status_d[ST_EXL] = 1'b0;
        end else begin
            status_d = status_d;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            badvaddr_q <= 32'h0000_0000;
            count_q    <= 32'h0000_0000;
            compare_q  <= 32'h0000_0000;
            status_q   <= STATUS_RST;
            epc_q      <= 32'h0000_0000;
            cause_q    <= '0;
            tick_q     <= 1'b0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            tick_q     <= tick_d;
        end
    end

endmodule
